inv_key_sched: RTL and testbench



---
 rtl/aes_pkg.sv | 34 +++
 rtl/inv_key_step.sv | 58 +++++
 rtl/s_box.sv | 31 +++
 rtl/inv_key_sched.sv | 120 ++++++++++++
 tb/tb_inv_key_sched.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg - shared AES-128 constants, key-schedule FSM state type and rcon lookup.
// Used by inv_key_sched and inv_key_step.
// Build option: INV_KEY_FWD_EN (uses the FWD state; see inv_key_sched).
package aes_pkg;

  localparam int NR = 10;   // AES-128 round count
  localparam int KW = 128;  // key width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FWD  = 2'd2
  } state_e;

  // Round constant for expansion step idx (0..9); out-of-range returns 0.
  function automatic logic [31:0] rcon(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h01;
      4'd1:    b = 8'h02;
      4'd2:    b = 8'h04;
      4'd3:    b = 8'h08;
      4'd4:    b = 8'h10;
      4'd5:    b = 8'h20;
      4'd6:    b = 8'h40;
      4'd7:    b = 8'h80;
      4'd8:    b = 8'h1b;
      4'd9:    b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h000000};
  endfunction

endpackage

// File: rtl/inv_key_step.sv
// inv_key_step - one AES-128 key-schedule step, purely combinational.
// Ports: i_key      - round key (w0 in [127:96])
//        i_rcon_idx - rcon index for this step
//        o_prev_key - key of the preceding round (inverse step)
//        i_fwd      - (INV_KEY_FWD_EN only) select forward SubWord source
//        o_next_key - (INV_KEY_FWD_EN only) key of the following round
// Build option: INV_KEY_FWD_EN adds the forward step sharing the same S-boxes.
module inv_key_step
  import aes_pkg::*;
(
  input  logic [KW-1:0] i_key,
  input  logic [3:0]    i_rcon_idx,
`ifdef INV_KEY_FWD_EN
  input  logic          i_fwd,
  output logic [KW-1:0] o_next_key,
`endif
  output logic [KW-1:0] o_prev_key
);

  logic [31:0] w_k0, w_k1, w_k2, w_k3;
  logic [31:0] w_p1, w_p2, w_p3;
  logic [31:0] w_sub_src, w_rot, w_sub, w_rc;

  assign {w_k0, w_k1, w_k2, w_k3} = i_key;
  assign w_rc = rcon(i_rcon_idx);

  assign w_p3 = w_k3 ^ w_k2;
  assign w_p2 = w_k2 ^ w_k1;
  assign w_p1 = w_k1 ^ w_k0;

  // Inverse step rebuilds the previous w3 first; forward step uses the current w3.
`ifdef INV_KEY_FWD_EN
  assign w_sub_src = i_fwd ? w_k3 : w_p3;
`else
  assign w_sub_src = w_p3;
`endif

  assign w_rot = {w_sub_src[23:0], w_sub_src[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    s_box u_s_box (
      .i_in  (w_rot[8*i +: 8]),
      .o_out (w_sub[8*i +: 8])
    );
  end

  assign o_prev_key = {w_k0 ^ w_sub ^ w_rc, w_p1, w_p2, w_p3};

`ifdef INV_KEY_FWD_EN
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  assign w_n0 = w_k0 ^ w_sub ^ w_rc;
  assign w_n1 = w_k1 ^ w_n0;
  assign w_n2 = w_k2 ^ w_n1;
  assign w_n3 = w_k3 ^ w_n2;
  assign o_next_key = {w_n0, w_n1, w_n2, w_n3};
`endif

endmodule

// File: rtl/s_box.sv
// s_box - AES forward S-box, combinational byte substitution.
// Ports: i_in  - input byte
//        o_out - substituted byte
module s_box (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  // Entry 0 sits in the top byte, so entry x starts at bit 2047-8x = {~x,3'b111}.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_out = SBOX[{~i_in, 3'b111} -: 8];

endmodule

// File: rtl/inv_key_sched.sv
// inv_key_sched - iterative AES-128 inverse key schedule.
// Streams round keys 10..0 over a valid/ready handshake, one step per transfer.
// Ports: clk, rst (async, active high)
//        start, key_in      - load request and key (round-10 key, or cipher key
//                             when INV_KEY_FWD_EN is defined)
//        busy               - stream in progress
//        rk_valid, rk_ready - handshake for rk_out/rk_idx
//        rk_out, rk_idx     - current round key and its round number
//        done               - one-cycle pulse after the round-0 transfer
// Build option: INV_KEY_FWD_EN - expand the cipher key forward to round 10 first.
//
// state | meaning
// IDLE  | waiting for start
// EMIT  | presenting rk_out; steps back one round per transfer
// FWD   | forward expansion to round 10 (INV_KEY_FWD_EN only)
module inv_key_sched
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] key_in,
  output logic          busy,
  output logic          rk_valid,
  input  logic          rk_ready,
  output logic [KW-1:0] rk_out,
  output logic [3:0]    rk_idx,
  output logic          done
);

  state_e        r_state;
  logic [KW-1:0] r_key;
  logic [3:0]    r_idx;
  logic          r_busy, r_valid, r_done;

  logic [3:0]    w_rcon_idx;
  logic [KW-1:0] w_prev_key;

`ifdef INV_KEY_FWD_EN
  logic          w_fwd;
  logic [KW-1:0] w_next_key;
  // During FWD r_idx counts the forward step (0..9) and doubles as rcon index.
  assign w_fwd      = (r_state == FWD);
  assign w_rcon_idx = w_fwd ? r_idx : r_idx - 4'd1;
`else
  assign w_rcon_idx = r_idx - 4'd1;
`endif

  inv_key_step u_step (
    .i_key      (r_key),
    .i_rcon_idx (w_rcon_idx),
`ifdef INV_KEY_FWD_EN
    .i_fwd      (w_fwd),
    .o_next_key (w_next_key),
`endif
    .o_prev_key (w_prev_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_key  <= key_in;
            r_busy <= 1'b1;
`ifdef INV_KEY_FWD_EN
            r_idx   <= 4'd0;
            r_state <= FWD;
`else
            r_idx   <= 4'(NR);
            r_valid <= 1'b1;
            r_state <= EMIT;
`endif
          end
        end
        EMIT: begin
          if (r_valid && rk_ready) begin
            if (r_idx == 4'd0) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_key <= w_prev_key;
              r_idx <= r_idx - 4'd1;
            end
          end
        end
`ifdef INV_KEY_FWD_EN
        FWD: begin
          r_key <= w_next_key;
          if (r_idx == 4'(NR - 1)) begin
            r_idx   <= 4'(NR);
            r_valid <= 1'b1;
            r_state <= EMIT;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign rk_valid = r_valid;
  assign rk_out   = r_key;
  assign rk_idx   = r_idx;
  assign done     = r_done;

endmodule

// File: tb/tb_inv_key_sched.sv
// tb_inv_key_sched - scoreboard bench for inv_key_sched.
// Expected round keys come from the FIPS-197 AES-128 example key schedule.
// Build option: INV_KEY_FWD_EN selects the cipher-key load and 11-cycle latency.
module tb_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic         busy, rk_valid, done;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_idx;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] exp_key_q[$];
  logic [3:0]   exp_idx_q[$];
  logic [127:0] ks [11];

`ifdef INV_KEY_FWD_EN
  localparam logic [127:0] LOAD_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam int           FIRST_WAIT = 10;
`else
  localparam logic [127:0] LOAD_KEY   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam int           FIRST_WAIT = 0;
`endif

  always #5 clk = ~clk;

  inv_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is sampled on the following posedge.
  task automatic begin_stream(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    for (int i = 10; i >= 0; i--) begin
      exp_key_q.push_back(ks[i]);
      exp_idx_q.push_back(4'(i));
    end
  endtask

  // Returns at the negedge where done is high (or right after a reset cut).
  task automatic run_stream(input bit rand_ready, input bit inject, input bit cut,
                            output int n_xfer);
    int           waits = 0;
    bit           seen_valid = 0;
    bit           stalled, last, r;
    logic [127:0] held_key, ek;
    logic [3:0]   held_idx, ei;
    n_xfer = 0;
    last   = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      start = 1'b0;
      if (!seen_valid) begin
        if (rk_valid) begin
          seen_valid = 1;
          check("valid_latency", 128'(waits), 128'(FIRST_WAIT));
          check("busy_on", 128'(busy), 128'd1);
        end else begin
          waits++;
          rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          @(negedge clk);
          continue;
        end
      end
      r        = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = r;
      stalled  = 0;
      if (cut && rk_valid && rk_idx == 4'd3) begin
        rst = 1'b1;
        #1;
        check("rst_valid", 128'(rk_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_idx", 128'(rk_idx), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_key", rk_out, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_key_q.delete();
        exp_idx_q.delete();
        return;
      end
      if (inject && rk_idx == 4'd5) begin
        start  = 1'b1;
        key_in = 128'h00112233445566778899aabbccddeeff;
      end
      if (rk_valid && r) begin
        if (exp_key_q.size() == 0) begin
          check("sb_empty", 128'd1, 128'd0);
        end else begin
          ek = exp_key_q.pop_front();
          ei = exp_idx_q.pop_front();
          check("rk_out", rk_out, ek);
          check("rk_idx", 128'(rk_idx), 128'(ei));
          n_xfer++;
          last = (rk_idx == 4'd0);
        end
      end else if (rk_valid) begin
        stalled  = 1;
        held_key = rk_out;
        held_idx = rk_idx;
      end
      @(negedge clk);
      if (stalled) begin
        check("stall_key", rk_out, held_key);
        check("stall_idx", 128'(rk_idx), 128'(held_idx));
      end
      if (last) begin
        check("done_pulse", 128'(done), 128'd1);
        check("end_valid", 128'(rk_valid), 128'd0);
        check("end_busy", 128'(busy), 128'd0);
        check("end_key", rk_out, ks[0]);
        return;
      end else begin
        check("no_early_done", 128'(done), 128'd0);
      end
    end
    check("timeout", 128'd1, 128'd0);
  endtask

  int n;

  initial begin
    ks[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    ks[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    ks[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    ks[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    ks[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    ks[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    ks[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    ks[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    ks[9]  = 128'hac7766f319fadc2128d12941575c006e;
    ks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst      = 1'b1;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", 128'(rk_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_idx", 128'(rk_idx), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_key", rk_out, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // continuous ready
    begin_stream(LOAD_KEY);
    run_stream(0, 0, 0, n);
    check("xfers_cont", 128'(n), 128'd11);
    @(negedge clk);
    check("done_one_cycle", 128'(done), 128'd0);

    // random backpressure
    begin_stream(LOAD_KEY);
    run_stream(1, 0, 0, n);
    check("xfers_rand", 128'(n), 128'd11);
    check("sb_drain_rand", 128'(exp_key_q.size()), 128'd0);

    // start while busy is ignored
    @(negedge clk);
    begin_stream(LOAD_KEY);
    run_stream(0, 1, 0, n);
    check("xfers_inject", 128'(n), 128'd11);

    // reset mid-stream, then fresh start
    @(negedge clk);
    begin_stream(LOAD_KEY);
    run_stream(0, 0, 1, n);
    @(negedge clk);
    begin_stream(LOAD_KEY);
    run_stream(0, 0, 0, n);
    check("xfers_after_rst", 128'(n), 128'd11);

    // back-to-back: start in the done cycle
    begin_stream(LOAD_KEY);
    run_stream(1, 0, 0, n);
    check("xfers_b2b", 128'(n), 128'd11);
    check("sb_drain_end", 128'(exp_key_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
